// File: rtl/pipe_mips_fwd.sv
`default_nettype none
// pipe_mips_fwd: single-clock 5-stage MIPS-style core with EX bypass or interlock,
// load-use stall, branch flush, halt squash, preload and debug ports. Revision 1.0
module pipe_mips_fwd #(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024,
   parameter int RESET_PC   = 0,
   parameter int FORWARDING = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              prog_we,
   input  logic              prog_sel,
   input  logic [15:0]       prog_addr,
   input  logic [31:0]       prog_wdata,
   input  logic [4:0]        dbg_reg_addr,
   output logic [DATA_W-1:0] dbg_reg_data,
   input  logic [15:0]       dbg_mem_addr,
   output logic [DATA_W-1:0] dbg_mem_data,
   output logic              halted,
   output logic [31:0]       retire_cnt,
   output logic [31:0]       stall_cnt
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [5:0] c_OP_LW    = 6'b001000;
   localparam logic [5:0] c_OP_SW    = 6'b001001;
   localparam logic [5:0] c_OP_ADDI  = 6'b001010;
   localparam logic [5:0] c_OP_SUBI  = 6'b001011;
   localparam logic [5:0] c_OP_SLTI  = 6'b001100;
   localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
   localparam logic [5:0] c_OP_BEQZ  = 6'b001110;

   logic [31:0]       r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
   logic [DATA_W-1:0] r_rf   [32];
   logic [IAW-1:0]    r_pc;
   logic              r_halted;
   logic [31:0]       r_retire_cnt, r_stall_cnt;

   logic              r_ifid_v;
   logic [31:0]       r_ifid_ir;
   logic [IAW-1:0]    r_ifid_npc;

   logic              r_idex_v, r_idex_rr, r_idex_wr, r_idex_ld, r_idex_st, r_idex_br, r_idex_bez, r_idex_hlt;
   logic [2:0]        r_idex_fn;
   logic [4:0]        r_idex_rs, r_idex_rt, r_idex_dst;
   logic [DATA_W-1:0] r_idex_a, r_idex_b, r_idex_imm;
   logic [IAW-1:0]    r_idex_npc;

   logic              r_exmem_v, r_exmem_wr, r_exmem_ld, r_exmem_st, r_exmem_hlt;
   logic [4:0]        r_exmem_dst;
   logic [DATA_W-1:0] r_exmem_res, r_exmem_sdata;

   logic              r_memwb_v, r_memwb_wr, r_memwb_hlt;
   logic [4:0]        r_memwb_dst;
   logic [DATA_W-1:0] r_memwb_res;

   // ---------------- decode ----------------
   logic [5:0]        w_id_op;
   logic [4:0]        w_id_rs, w_id_rt, w_id_dst;
   logic              w_id_rr, w_id_rm, w_id_ld, w_id_st, w_id_br, w_id_hlt, w_id_wr, w_id_use_rt;
   logic [2:0]        w_id_fn;
   logic [DATA_W-1:0] w_id_imm, w_id_a, w_id_b;
   logic              w_wb_we;

   assign w_id_op     = r_ifid_ir[31:26];
   assign w_id_rs     = r_ifid_ir[25:21];
   assign w_id_rt     = r_ifid_ir[20:16];
   assign w_id_imm    = DATA_W'($signed(r_ifid_ir[15:0]));
   assign w_id_rr     = (w_id_op < 6'd6);
   assign w_id_rm     = (w_id_op == c_OP_ADDI) | (w_id_op == c_OP_SUBI) | (w_id_op == c_OP_SLTI);
   assign w_id_ld     = (w_id_op == c_OP_LW);
   assign w_id_st     = (w_id_op == c_OP_SW);
   assign w_id_br     = (w_id_op == c_OP_BNEQZ) | (w_id_op == c_OP_BEQZ);
   assign w_id_hlt    = ~(w_id_rr | w_id_rm | w_id_ld | w_id_st | w_id_br);
   assign w_id_wr     = w_id_rr | w_id_rm | w_id_ld;
   assign w_id_dst    = w_id_rr ? r_ifid_ir[15:11] : w_id_rt;
   assign w_id_use_rt = w_id_rr | w_id_st | w_id_br;
   assign w_id_fn     = w_id_rr ? w_id_op[2:0] :
                        (w_id_op == c_OP_SUBI) ? 3'd1 :
                        (w_id_op == c_OP_SLTI) ? 3'd4 : 3'd0;

   // WB writes first, so a same-cycle ID read sees the committing value
   assign w_wb_we = r_memwb_v & r_memwb_wr & (r_memwb_dst != 5'd0);
   assign w_id_a  = (w_id_rs == 5'd0) ? '0 : (w_wb_we && r_memwb_dst == w_id_rs) ? r_memwb_res : r_rf[w_id_rs];
   assign w_id_b  = (w_id_rt == 5'd0) ? '0 : (w_wb_we && r_memwb_dst == w_id_rt) ? r_memwb_res : r_rf[w_id_rt];

   function automatic logic f_hit(input logic v, input logic wr, input logic [4:0] dst,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic use_rs, input logic use_rt);
      f_hit = v & wr & (dst != 5'd0) & ((use_rs & (dst == rs)) | (use_rt & (dst == rt)));
   endfunction

   // ---------------- hazards and bypass ----------------
   logic              w_hazard;
   logic [DATA_W-1:0] w_ex_a, w_ex_b;

   generate
      if (FORWARDING != 0) begin : g_fwd
         logic w_em_fwd;
         assign w_em_fwd = r_exmem_v & r_exmem_wr & ~r_exmem_ld & (r_exmem_dst != 5'd0);
         assign w_hazard = f_hit(r_idex_v, r_idex_ld, r_idex_dst, w_id_rs, w_id_rt, ~w_id_hlt, w_id_use_rt);
         assign w_ex_a   = (w_em_fwd && r_exmem_dst == r_idex_rs) ? r_exmem_res :
                           (w_wb_we && r_memwb_dst == r_idex_rs)  ? r_memwb_res : r_idex_a;
         assign w_ex_b   = (w_em_fwd && r_exmem_dst == r_idex_rt) ? r_exmem_res :
                           (w_wb_we && r_memwb_dst == r_idex_rt)  ? r_memwb_res : r_idex_b;
      end else begin : g_ilk
         assign w_hazard = f_hit(r_idex_v, r_idex_wr, r_idex_dst, w_id_rs, w_id_rt, ~w_id_hlt, w_id_use_rt) |
                           f_hit(r_exmem_v, r_exmem_wr, r_exmem_dst, w_id_rs, w_id_rt, ~w_id_hlt, w_id_use_rt);
         assign w_ex_a   = r_idex_a;
         assign w_ex_b   = r_idex_b;
      end
   endgenerate

   // ---------------- execute ----------------
   logic [DATA_W-1:0] w_ex_op2, w_ex_res;
   logic              w_ex_taken;
   logic [IAW-1:0]    w_ex_target;

   assign w_ex_op2    = r_idex_rr ? w_ex_b : r_idex_imm;
   assign w_ex_taken  = r_idex_v & r_idex_br & (r_idex_bez ? (w_ex_a == '0) : (w_ex_a != '0));
   assign w_ex_target = r_idex_npc + r_idex_imm[IAW-1:0];

   always_comb begin
      w_ex_res = '0;
      case (r_idex_fn)
         3'd1:    w_ex_res = w_ex_a - w_ex_op2;
         3'd2:    w_ex_res = w_ex_a & w_ex_op2;
         3'd3:    w_ex_res = w_ex_a | w_ex_op2;
         3'd4:    w_ex_res[0] = ($signed(w_ex_a) < $signed(w_ex_op2));
         3'd5:    w_ex_res = w_ex_a * w_ex_op2;
         default: w_ex_res = w_ex_a + w_ex_op2;
      endcase
   end

   // ---------------- pipeline control ----------------
   logic           w_adv, w_stall, w_fetch_stop, w_idex_ld, w_ifid_ld;
   logic [DAW-1:0] w_mem_addr;

   assign w_adv        = run & ~r_halted;
   assign w_stall      = r_ifid_v & w_hazard;
   // once a halt is decoded, nothing younger is fetched
   assign w_fetch_stop = (r_ifid_v & w_id_hlt) | (r_idex_v & r_idex_hlt) |
                         (r_exmem_v & r_exmem_hlt) | (r_memwb_v & r_memwb_hlt);
   assign w_idex_ld    = w_adv & ~w_ex_taken & ~w_stall;
   assign w_ifid_ld    = w_idex_ld & ~w_fetch_stop;
   assign w_mem_addr   = r_exmem_res[DAW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= IAW'(RESET_PC);
         r_ifid_v     <= 1'b0;
         r_idex_v     <= 1'b0;
         r_exmem_v    <= 1'b0;
         r_memwb_v    <= 1'b0;
         r_halted     <= 1'b0;
         r_retire_cnt <= '0;
         r_stall_cnt  <= '0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (w_adv) begin
         r_exmem_v <= r_idex_v;
         r_memwb_v <= r_exmem_v;
         if (w_ex_taken) begin
            r_pc     <= w_ex_target;
            r_ifid_v <= 1'b0;
            r_idex_v <= 1'b0;
         end else if (w_stall) begin
            r_idex_v    <= 1'b0;
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end else begin
            r_idex_v <= r_ifid_v;
            r_ifid_v <= ~w_fetch_stop;
            if (!w_fetch_stop) r_pc <= r_pc + IAW'(1);
         end
         if (r_memwb_v) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
            if (r_memwb_hlt) r_halted <= 1'b1;
         end
         if (w_wb_we) r_rf[r_memwb_dst] <= r_memwb_res;
      end
   end

   // payload registers are qualified by the valid bits above and need no reset
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_exmem_wr    <= r_idex_wr;
         r_exmem_ld    <= r_idex_ld;
         r_exmem_st    <= r_idex_st;
         r_exmem_hlt   <= r_idex_hlt;
         r_exmem_dst   <= r_idex_dst;
         r_exmem_res   <= w_ex_res;
         r_exmem_sdata <= w_ex_b;
         r_memwb_wr    <= r_exmem_wr;
         r_memwb_hlt   <= r_exmem_hlt;
         r_memwb_dst   <= r_exmem_dst;
         r_memwb_res   <= r_exmem_ld ? r_dmem[w_mem_addr] : r_exmem_res;
      end
      if (w_idex_ld) begin
         {r_idex_rr, r_idex_wr, r_idex_ld, r_idex_st} <= {w_id_rr, w_id_wr, w_id_ld, w_id_st};
         {r_idex_br, r_idex_hlt} <= {w_id_br, w_id_hlt};
         r_idex_bez <= (w_id_op == c_OP_BEQZ);
         r_idex_fn  <= w_id_fn;
         r_idex_rs  <= w_id_rs;
         r_idex_rt  <= w_id_rt;
         r_idex_dst <= w_id_dst;
         r_idex_a   <= w_id_a;
         r_idex_b   <= w_id_b;
         r_idex_imm <= w_id_imm;
         r_idex_npc <= r_ifid_npc;
      end
      if (w_ifid_ld) begin
         r_ifid_ir  <= r_imem[r_pc];
         r_ifid_npc <= r_pc + IAW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (prog_we && !run) begin
         if (prog_sel) r_dmem[prog_addr[DAW-1:0]] <= DATA_W'(prog_wdata);
         else          r_imem[prog_addr[IAW-1:0]] <= prog_wdata;
      end else if (w_adv && r_exmem_v && r_exmem_st) begin
         r_dmem[w_mem_addr] <= r_exmem_sdata;
      end
   end

   logic w_unused_addr_bits;
   assign w_unused_addr_bits = ^{prog_addr, dbg_mem_addr};

   assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? '0 : r_rf[dbg_reg_addr];
   assign dbg_mem_data = r_dmem[dbg_mem_addr[DAW-1:0]];
   assign halted       = r_halted;
   assign retire_cnt   = r_retire_cnt;
   assign stall_cnt    = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_mips_fwd.sv
`default_nettype none
// tb_pipe_mips_fwd: directed programs run on a bypassing core and an interlock-only core.
module tb_pipe_mips_fwd;
   localparam logic [5:0] ADD = 6'b000000, LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010;
   localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
   localparam logic [31:0] HLT = 32'hFC00_0000;

   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, prog_we = 1'b0, prog_sel = 1'b0;
   logic [15:0] prog_addr = '0, dbg_mem_addr = '0;
   logic [31:0] prog_wdata = '0;
   logic [4:0]  dbg_reg_addr = '0;
   logic [31:0] reg_f, reg_i, mem_f, mem_i, ret_f, ret_i, stl_f, stl_i;
   logic        halted_f, halted_i;
   int          n_chk = 0, n_pass = 0, edge_n = 0, h_f = 0, h_i = 0;

   always #5 clk = ~clk;

   pipe_mips_fwd #(.FORWARDING(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_sel(prog_sel),
      .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_reg_addr(dbg_reg_addr),
      .dbg_reg_data(reg_f), .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(mem_f),
      .halted(halted_f), .retire_cnt(ret_f), .stall_cnt(stl_f));

   pipe_mips_fwd #(.FORWARDING(0)) dut_i (
      .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_sel(prog_sel),
      .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_reg_addr(dbg_reg_addr),
      .dbg_reg_data(reg_i), .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(mem_i),
      .halted(halted_i), .retire_cnt(ret_i), .stall_cnt(stl_i));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] f_r(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   task automatic wr(input logic sel, input int a, input logic [31:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_sel = sel; prog_addr = 16'(a); prog_wdata = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      run = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      edge_n = 0; h_f = 0; h_i = 0;
   endtask

   task automatic step(input int n);
      run = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         edge_n++;
         #1;
         if (halted_f && h_f == 0) h_f = edge_n;
         if (halted_i && h_i == 0) h_i = edge_n;
      end
   endtask

   task automatic run_to_halt();
      while (!(halted_f && halted_i) && edge_n < 60) step(1);
      run = 1'b0;
   endtask

   task automatic rd_reg(input logic [4:0] a);
      dbg_reg_addr = a; #1;
   endtask

   task automatic rd_mem(input int a);
      dbg_mem_addr = 16'(a); #1;
   endtask

   task automatic load_chain();
      wr(0, 0, f_i(ADDI, 0, 1, 16'd10));
      wr(0, 1, f_i(ADDI, 0, 2, 16'd20));
      wr(0, 2, f_r(ADD, 3, 1, 2));
      wr(0, 3, HLT);
   endtask

   task automatic load_branch(input logic [5:0] bop);
      wr(0, 0, f_i(ADDI, 0, 1, 16'd0));
      wr(0, 1, f_i(bop, 1, 0, 16'd2));
      wr(0, 2, f_i(ADDI, 0, 2, 16'd1));
      wr(0, 3, f_i(ADDI, 0, 3, 16'd1));
      wr(0, 4, f_i(ADDI, 0, 4, 16'd9));
      wr(0, 5, HLT);
   endtask

   initial begin
      // reset state
      do_reset();
      rd_reg(5'd3);
      check("rst_halted", {31'd0, halted_f}, 32'd0);
      check("rst_retire", ret_f, 32'd0);
      check("rst_stall", stl_i, 32'd0);
      check("rst_r3", reg_f, 32'd0);

      // dependent chain: bypass vs interlock
      load_chain();
      run_to_halt();
      check("chain_halt_edge_fwd", 32'(h_f), 32'd8);
      check("chain_halt_edge_ilk", 32'(h_i), 32'd10);
      rd_reg(5'd3);
      check("chain_r3_fwd", reg_f, 32'd30);
      check("chain_r3_ilk", reg_i, 32'd30);
      check("chain_retire_fwd", ret_f, 32'd4);
      check("chain_stall_fwd", stl_f, 32'd0);
      check("chain_stall_ilk", stl_i, 32'd2);

      // reset in the middle of the chain, then rerun with a run=0 pause
      do_reset();
      step(6);
      rd_reg(5'd1);
      check("mid_r1_before", reg_f, 32'd10);
      rst_n = 1'b0; run = 1'b0; #1;
      check("mid_retire", ret_f, 32'd0);
      check("mid_stall_ilk", stl_i, 32'd0);
      check("mid_halted", {31'd0, halted_f}, 32'd0);
      check("mid_r1_after", reg_f, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      edge_n = 0; h_f = 0; h_i = 0;
      step(5);
      run = 1'b0;
      check("pause_retire_a", ret_f, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("pause_retire_b", ret_f, 32'd1);
      run_to_halt();
      check("rerun_halt_edge_fwd", 32'(h_f), 32'd8);
      check("rerun_halt_edge_ilk", 32'(h_i), 32'd10);
      rd_reg(5'd3);
      check("rerun_r3", reg_f, 32'd30);

      // load-use
      do_reset();
      wr(1, 5, 32'd7);
      wr(0, 0, f_i(LW, 0, 1, 16'd5));
      wr(0, 1, f_r(ADD, 2, 1, 1));
      wr(0, 2, HLT);
      run_to_halt();
      rd_reg(5'd2);
      check("lu_r2_fwd", reg_f, 32'd14);
      check("lu_r2_ilk", reg_i, 32'd14);
      check("lu_stall_fwd", stl_f, 32'd1);
      check("lu_retire_fwd", ret_f, 32'd3);

      // branches
      do_reset();
      load_branch(BEQZ);
      run_to_halt();
      rd_reg(5'd2); check("beqz_r2", reg_f, 32'd0); check("beqz_r2_ilk", reg_i, 32'd0);
      rd_reg(5'd3); check("beqz_r3", reg_f, 32'd0);
      rd_reg(5'd4); check("beqz_r4", reg_f, 32'd9); check("beqz_r4_ilk", reg_i, 32'd9);
      check("beqz_retire", ret_f, 32'd4);
      do_reset();
      load_branch(BNEQZ);
      run_to_halt();
      rd_reg(5'd2); check("bneqz_r2", reg_f, 32'd1);
      rd_reg(5'd3); check("bneqz_r3", reg_f, 32'd1); check("bneqz_r3_ilk", reg_i, 32'd1);
      check("bneqz_retire", ret_f, 32'd6);

      // stores, r0 discard, no commit after hlt
      do_reset();
      wr(1, 3, 32'h55);
      wr(1, 4, 32'h0);
      wr(0, 0, f_i(ADDI, 0, 0, 16'd5));
      wr(0, 1, f_r(ADD, 1, 0, 0));
      wr(0, 2, f_i(SW, 0, 1, 16'd3));
      wr(0, 3, f_i(ADDI, 0, 5, 16'hFFFF));
      wr(0, 4, f_i(SW, 0, 5, 16'd4));
      wr(0, 5, HLT);
      wr(0, 6, f_i(ADDI, 0, 6, 16'd7));
      run_to_halt();
      step(5);
      run = 1'b0;
      rd_reg(5'd1); check("st_r1", reg_f, 32'd0);
      rd_reg(5'd0); check("st_r0", reg_f, 32'd0);
      rd_reg(5'd6); check("st_r6_after_hlt", reg_f, 32'd0); check("st_r6_ilk", reg_i, 32'd0);
      rd_mem(3); check("st_dmem3", mem_f, 32'd0);
      rd_mem(4); check("st_dmem4", mem_f, 32'hFFFF_FFFF); check("st_dmem4_ilk", mem_i, 32'hFFFF_FFFF);
      check("st_retire_frozen", ret_f, 32'd6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
